gpio_irq_ctrl: RTL and testbench

GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

---
 rtl/gpio_irq_ctrl.sv | 138 +++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_ctrl.sv
// ============================================================================
// Module     : gpio_irq_ctrl
// Description: GPIO edge-to-interrupt controller with a single-outstanding
//              irq_id/ack handshake. Define GPIO_IRQ_CTRL_RR_EN for round-robin
//              arbitration; fixed lowest-index priority otherwise.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_irq_ctrl #(
  parameter int C_DWIDTH  = 32,
  parameter int C_IDWIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [C_DWIDTH-1:0]  l_gpio_i,
  input  logic [C_DWIDTH-1:0]  irq_en,
  input  logic [C_DWIDTH-1:0]  rise_en,
  input  logic [C_DWIDTH-1:0]  fall_en,
  input  logic                 irq_ack,
  output logic                 irq,
  output logic                 irq_valid,
  output logic [C_IDWIDTH-1:0] irq_id,
  output logic [C_DWIDTH-1:0]  pending
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                state;
  logic [C_DWIDTH-1:0]   prev;
  logic                  primed;
  logic [C_DWIDTH-1:0]   edge_hit;
  logic [C_DWIDTH-1:0]   set_mask;
  logic [C_DWIDTH-1:0]   clr_mask;
  logic [C_DWIDTH-1:0]   pending_nxt;
  logic [C_IDWIDTH-1:0]  winner;
  logic                  ack_fire;

  // The first cycle after reset only captures the pin levels, so a pin that
  // is already high or low at release never looks like an edge.
  always_comb begin
    edge_hit = '0;
    if (primed) begin
      edge_hit = (rise_en & l_gpio_i & ~prev) | (fall_en & ~l_gpio_i & prev);
    end
  end

  assign set_mask = edge_hit & irq_en;
  assign ack_fire = (state == PRESENT) && irq_ack;

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < C_DWIDTH; i++) begin
      clr_mask[i] = ack_fire && (irq_id == C_IDWIDTH'(i));
    end
  end

  // Set after clear: a fresh edge on the acknowledged pin keeps it pending.
  assign pending_nxt = (pending & ~clr_mask) | set_mask;

`ifdef GPIO_IRQ_CTRL_RR_EN
  logic [C_IDWIDTH-1:0]  rr_ptr;
  logic [2*C_DWIDTH-1:0] pend_rot;
  logic [C_IDWIDTH:0]    rr_sum;

  // Rotate pending so the search origin sits at bit 0, pick the lowest set
  // bit, then map the offset back to an absolute pin index.
  always_comb begin
    pend_rot = {pending, pending} >> rr_ptr;
    rr_sum   = '0;
    for (int k = C_DWIDTH - 1; k >= 0; k--) begin
      if (pend_rot[k]) begin
        rr_sum = {1'b0, rr_ptr} + (C_IDWIDTH + 1)'(k);
      end
    end
    if (rr_sum >= (C_IDWIDTH + 1)'(C_DWIDTH)) begin
      rr_sum = rr_sum - (C_IDWIDTH + 1)'(C_DWIDTH);
    end
    winner = rr_sum[C_IDWIDTH-1:0];
  end
`else
  always_comb begin
    winner = '0;
    for (int i = C_DWIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        winner = C_IDWIDTH'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev      <= '0;
      primed    <= 1'b0;
      pending   <= '0;
      irq       <= 1'b0;
      irq_valid <= 1'b0;
      irq_id    <= '0;
      state     <= IDLE;
`ifdef GPIO_IRQ_CTRL_RR_EN
      rr_ptr    <= '0;
`endif
    end else begin
      prev    <= l_gpio_i;
      primed  <= 1'b1;
      pending <= pending_nxt;
      irq     <= |pending_nxt;
      case (state)
        IDLE: begin
          if (|pending) begin
            irq_id    <= winner;
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          // Grant is frozen until acknowledged; enables and edges do not move it.
          if (irq_ack) begin
            irq_valid <= 1'b0;
            state     <= IDLE;
`ifdef GPIO_IRQ_CTRL_RR_EN
            rr_ptr    <= (irq_id == C_IDWIDTH'(C_DWIDTH - 1)) ? '0
                                                               : irq_id + C_IDWIDTH'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl: directed pin patterns, a cycle-level reference
// model checked every cycle, and literal expectations for key scenarios.
`default_nettype none

module tb_gpio_irq_ctrl;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  l_gpio_i = '0;
  logic [N-1:0]  irq_en = '0;
  logic [N-1:0]  rise_en = '0;
  logic [N-1:0]  fall_en = '0;
  logic          irq_ack = 1'b0;
  logic          irq;
  logic          irq_valid;
  logic [4:0]    irq_id;
  logic [N-1:0]  pending;

  int tests = 0;
  int failed = 0;

  // Reference model state
  logic [N-1:0] m_prev = '0;
  logic [N-1:0] m_pend = '0;
  bit           m_primed = 1'b0;
  bit           m_valid = 1'b0;
  bit           m_irq = 1'b0;
  int           m_id = 0;
  int           m_ptr = 0;

`ifdef GPIO_IRQ_CTRL_RR_EN
  localparam int A1 = 5, A2 = 2;
`else
  localparam int A1 = 2, A2 = 5;
`endif

  gpio_irq_ctrl #(.C_DWIDTH(N), .C_IDWIDTH(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .l_gpio_i  (l_gpio_i),
    .irq_en    (irq_en),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .irq_ack   (irq_ack),
    .irq       (irq),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // First pending pin found when scanning upward from 'start', wrapping.
  function automatic int pick(input logic [N-1:0] p, input int start);
    for (int k = 0; k < N; k++) begin
      if (p[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_primed = 0; m_valid = 0; m_irq = 0; m_id = 0; m_ptr = 0;
  endtask

  task automatic compare_all();
    check("pending", pending, m_pend);
    check("irq", 32'(irq), 32'(m_irq));
    check("irq_valid", 32'(irq_valid), 32'(m_valid));
    check("irq_id", 32'(irq_id), 32'(m_id));
  endtask

  // One clock: derive the model's next state from the current inputs,
  // let the DUT take its edge, then compare just after it.
  task automatic tick();
    logic [N-1:0] edges, npend;
    bit nvalid;
    int nid, nptr;
    npend = m_pend; nvalid = m_valid; nid = m_id; nptr = m_ptr;
    if (reset_n) begin
      edges = m_primed ? ((rise_en & l_gpio_i & ~m_prev) | (fall_en & ~l_gpio_i & m_prev)) : '0;
      npend = m_pend | (edges & irq_en);
      if (m_valid && irq_ack) begin
        npend[m_id] = edges[m_id] & irq_en[m_id];
        nvalid = 0;
`ifdef GPIO_IRQ_CTRL_RR_EN
        nptr = (m_id + 1) % N;
`endif
      end else if (!m_valid && m_pend != '0) begin
        nvalid = 1;
        nid = pick(m_pend, m_ptr);
      end
    end
    @(posedge clk);
    #1;
    if (reset_n) begin
      m_prev = l_gpio_i; m_primed = 1; m_pend = npend; m_irq = |npend;
      m_valid = nvalid; m_id = nid; m_ptr = nptr;
    end else begin
      model_reset();
    end
    compare_all();
  endtask

  task automatic wait_valid(input int exp_id);
    int budget = 0;
    while (!irq_valid && budget < 20) begin
      tick();
      budget++;
    end
    check("grant_seen", 32'(irq_valid), 32'd1);
    check("grant_id", 32'(irq_id), 32'(exp_id));
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("valid_after_ack", 32'(irq_valid), 32'd0);
  endtask

  task automatic ack_grant(input int exp_id);
    wait_valid(exp_id);
    do_ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all pins high and every edge type enabled.
    l_gpio_i = '1; irq_en = '1; rise_en = '1; fall_en = '1;
    #1;
    compare_all();
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    check("no_spurious_pending", pending, 32'h0);
    check("no_spurious_irq", 32'(irq), 32'd0);

    // Quiesce pins without creating edges, then configure.
    rise_en = '0; fall_en = '0;
    tick();
    l_gpio_i = '0;
    tick(); tick();
    irq_en = 32'hFFFF_FF7F; rise_en = '1; fall_en = '0;
    tick();

    // Single rising edge on pin 3: pending next cycle, grant the cycle after.
    l_gpio_i = 32'h08;
    tick();
    check("p3_pending", pending, 32'h8);
    check("p3_irq", 32'(irq), 32'd1);
    check("p3_not_yet_valid", 32'(irq_valid), 32'd0);
    tick();
    check("p3_valid", 32'(irq_valid), 32'd1);
    check("p3_id", 32'(irq_id), 32'd3);
    do_ack();
    check("p3_cleared", pending, 32'h0);

    // Lone grant of pin 2, then 2 and 5 together.
    l_gpio_i = 32'h0C; tick();
    ack_grant(2);
    l_gpio_i = 32'h08; tick();
    l_gpio_i = 32'h2C; tick();
    check("both_latched", pending, 32'h24);
    ack_grant(A1);
    ack_grant(A2);

    // Lone grant of pin 5, then 2 and 5 together again.
    l_gpio_i = 32'h08; tick();
    l_gpio_i = 32'h28; tick();
    ack_grant(5);
    l_gpio_i = 32'h08; tick();
    l_gpio_i = 32'h2C; tick();
    ack_grant(2);
    ack_grant(5);

    // Pin 4 re-fires in the very cycle its grant is acknowledged.
    l_gpio_i = 32'h3C; tick();
    wait_valid(4);
    l_gpio_i = 32'h2C; tick();
    l_gpio_i = 32'h3C; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("p4_kept", pending, 32'h10);
    check("p4_idle_gap", 32'(irq_valid), 32'd0);
    tick();
    check("p4_represent_valid", 32'(irq_valid), 32'd1);
    check("p4_represent_id", 32'(irq_id), 32'd4);
    do_ack();

    // Pin 7 disabled: toggles are discarded.
    l_gpio_i = 32'hBC; tick();
    l_gpio_i = 32'h3C; tick();
    l_gpio_i = 32'hBC; tick();
    check("p7_discarded", pending, 32'h0);
    // Pin 7 latched, then disabled: grant still held until ack.
    irq_en = '1;
    l_gpio_i = 32'h3C; tick();
    l_gpio_i = 32'hBC; tick();
    check("p7_latched", pending, 32'h80);
    irq_en = 32'hFFFF_FF7F;
    wait_valid(7);
    tick(); tick();
    check("p7_held_valid", 32'(irq_valid), 32'd1);
    check("p7_held_id", 32'(irq_id), 32'd7);
    do_ack();

    // Falling edge on pin 0.
    rise_en = 32'hFFFF_FFFE; fall_en = 32'h1;
    l_gpio_i = 32'hBD; tick();
    l_gpio_i = 32'hBC; tick();
    check("p0_fall", pending, 32'h1);
    ack_grant(0);

    // Reset asserted mid-grant clears everything immediately.
    l_gpio_i = 32'h2BC; tick();
    wait_valid(9);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 32'(irq_valid), 32'd0);
    check("rst_pending", pending, 32'h0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("rst_no_regrant", 32'(irq_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
